// File: rtl/legv8_pkg.sv
// Shared encodings for the LEGv8 multi-cycle controller: opcodes, instruction
// classes, ALU/SEU select codes, FSM states and error codes.
package legv8_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // CLS_ILL is the reset value of the latched class register.
    typedef enum logic [3:0] {
        CLS_ILL  = 4'd0,
        CLS_ADD  = 4'd1,
        CLS_SUB  = 4'd2,
        CLS_AND  = 4'd3,
        CLS_ORR  = 4'd4,
        CLS_ADDI = 4'd5,
        CLS_SUBI = 4'd6,
        CLS_LD   = 4'd7,
        CLS_ST   = 4'd8,
        CLS_CBZ  = 4'd9,
        CLS_B    = 4'd10
    } cls_t;

    localparam logic [10:0] OP_ADD     = 11'h458;
    localparam logic [10:0] OP_SUB     = 11'h658;
    localparam logic [10:0] OP_AND     = 11'h450;
    localparam logic [10:0] OP_ORR     = 11'h550;
    localparam logic [10:0] OP_ADDI_LO = 11'h488;
    localparam logic [10:0] OP_ADDI_HI = 11'h489;
    localparam logic [10:0] OP_SUBI_LO = 11'h688;
    localparam logic [10:0] OP_SUBI_HI = 11'h689;
    localparam logic [10:0] OP_LDUR    = 11'h7C2;
    localparam logic [10:0] OP_STUR    = 11'h7C0;
    localparam logic [10:0] OP_CBZ_LO  = 11'h5A0;
    localparam logic [10:0] OP_CBZ_HI  = 11'h5A7;
    localparam logic [10:0] OP_B_LO    = 11'h0A0;
    localparam logic [10:0] OP_B_HI    = 11'h0BF;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_ORR  = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam logic [1:0] SEU_I  = 2'b00;
    localparam logic [1:0] SEU_D  = 2'b01;
    localparam logic [1:0] SEU_CB = 2'b10;
    localparam logic [1:0] SEU_B  = 2'b11;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_ILL  = 2'b01;
    localparam logic [1:0] ERR_TO   = 2'b10;

    function automatic logic in_range(input logic [10:0] op,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi);
        return (op >= lo) && (op <= hi);
    endfunction

endpackage

// File: rtl/legv8_decode.sv
// Pure combinational opcode classifier: IR[31:21] -> instruction class.
module legv8_decode
    import legv8_pkg::*;
(
    input  logic [10:0] i_opcode,
    output cls_t        o_cls
);

    always_comb begin
        o_cls = CLS_ILL;
        if (i_opcode == OP_ADD)                               o_cls = CLS_ADD;
        else if (i_opcode == OP_SUB)                          o_cls = CLS_SUB;
        else if (i_opcode == OP_AND)                          o_cls = CLS_AND;
        else if (i_opcode == OP_ORR)                          o_cls = CLS_ORR;
        else if (in_range(i_opcode, OP_ADDI_LO, OP_ADDI_HI))  o_cls = CLS_ADDI;
        else if (in_range(i_opcode, OP_SUBI_LO, OP_SUBI_HI))  o_cls = CLS_SUBI;
        else if (i_opcode == OP_LDUR)                         o_cls = CLS_LD;
        else if (i_opcode == OP_STUR)                         o_cls = CLS_ST;
        else if (in_range(i_opcode, OP_CBZ_LO, OP_CBZ_HI))    o_cls = CLS_CBZ;
        else if (in_range(i_opcode, OP_B_LO, OP_B_HI))        o_cls = CLS_B;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB with a DMIO req/ack
// handshake, memory timeout, sticky error halt and retired-instruction counter.
module multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic             pc_src,
    output logic             reg2loc,
    output logic [1:0]       seu,
    output logic             alu_src,
    output logic [2:0]       alu_op,
    output logic             mem_req,
    output logic             mem_wr,
    output logic             mem_to_reg,
    output logic             reg_wr,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] retired
);

    state_t             r_state;
    state_t             w_next;
    cls_t               r_cls;
    cls_t               w_dec_cls;
    cls_t               w_cls;
    logic [TO_W-1:0]    r_to_cnt;
    logic [1:0]         r_err;
    logic [CNT_W-1:0]   r_retired;
    logic               w_retire;
    logic               w_to_expire;

    legv8_decode u_decode (
        .i_opcode (opcode),
        .o_cls    (w_dec_cls)
    );

    // In DECODE the class register is being loaded, so act on the live decode.
    assign w_cls = (r_state == ST_DECODE) ? w_dec_cls : r_cls;

    // Expiry is the MEM cycle that would push the wait count to MEM_TIMEOUT.
    assign w_to_expire = (r_state == ST_MEM) && !mem_ack &&
                         (r_to_cnt == TO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  w_next = run ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (w_cls == CLS_ILL)     w_next = ST_HALT;
                else if (w_cls == CLS_B)  w_next = ST_FETCH;
                else                      w_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (w_cls)
                    CLS_ADD, CLS_SUB, CLS_AND, CLS_ORR,
                    CLS_ADDI, CLS_SUBI:   w_next = ST_WB;
                    CLS_LD, CLS_ST:       w_next = ST_MEM;
                    CLS_CBZ:              w_next = ST_FETCH;
                    default:              w_next = ST_HALT;
                endcase
            end
            ST_MEM: begin
                if (mem_ack)           w_next = (w_cls == CLS_ST) ? ST_FETCH : ST_WB;
                else if (w_to_expire)  w_next = ST_HALT;
                else                   w_next = ST_MEM;
            end
            ST_WB:     w_next = ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_HALT;
        endcase
    end

    always_comb begin
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        seu        = SEU_I;
        alu_src    = 1'b0;
        alu_op     = ALU_AND;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_to_reg = 1'b0;
        reg_wr     = 1'b0;
        halted     = 1'b0;
        w_retire   = 1'b0;

        // ALU/SEU selects stay asserted from EXEC through MEM and WB so the
        // datapath result (address or writeback value) does not move.
        if (r_state == ST_EXEC || r_state == ST_MEM || r_state == ST_WB) begin
            case (w_cls)
                CLS_ADD:  alu_op = ALU_ADD;
                CLS_SUB:  alu_op = ALU_SUB;
                CLS_AND:  alu_op = ALU_AND;
                CLS_ORR:  alu_op = ALU_ORR;
                CLS_ADDI: begin alu_src = 1'b1; seu = SEU_I; alu_op = ALU_ADD; end
                CLS_SUBI: begin alu_src = 1'b1; seu = SEU_I; alu_op = ALU_SUB; end
                CLS_LD:   begin alu_src = 1'b1; seu = SEU_D; alu_op = ALU_ADD; end
                CLS_ST: begin
                    alu_src = 1'b1;
                    seu     = SEU_D;
                    alu_op  = ALU_ADD;
                    reg2loc = 1'b1;
                end
                default: ;
            endcase
        end

        case (r_state)
            ST_FETCH:  ir_wr = run;
            ST_DECODE: begin
                if (w_cls == CLS_B) begin
                    seu      = SEU_B;
                    pc_src   = 1'b1;
                    pc_wr    = 1'b1;
                    w_retire = 1'b1;
                end
            end
            ST_EXEC: begin
                if (w_cls == CLS_CBZ) begin
                    reg2loc  = 1'b1;
                    alu_op   = ALU_PASS;
                    alu_src  = 1'b0;
                    seu      = SEU_CB;
                    pc_src   = zero;
                    pc_wr    = 1'b1;
                    w_retire = 1'b1;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_wr  = (w_cls == CLS_ST);
                if (mem_ack && w_cls == CLS_ST) begin
                    pc_wr    = 1'b1;
                    w_retire = 1'b1;
                end
            end
            ST_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = (w_cls == CLS_LD);
                pc_wr      = 1'b1;
                w_retire   = 1'b1;
            end
            ST_HALT:   halted = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cls     <= CLS_ILL;
            r_to_cnt  <= '0;
            r_err     <= ERR_NONE;
            r_retired <= '0;
        end else begin
            if (r_state == ST_DECODE) begin
                r_cls <= w_dec_cls;
            end
            if (r_state == ST_MEM && !mem_ack) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
            if (r_state == ST_DECODE && w_dec_cls == CLS_ILL) begin
                r_err <= ERR_ILL;
            end else if (w_to_expire) begin
                r_err <= ERR_TO;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign state   = r_state;
    assign err     = r_err;
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: every cycle's full output vector and the
// retired count are queued as expectations and compared at the falling edge.
module tb_multicycle_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic       ir_wr;
        logic       pc_wr;
        logic       pc_src;
        logic       reg2loc;
        logic [1:0] seu;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       mem_req;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       reg_wr;
        logic [2:0] state;
        logic       halted;
        logic [1:0] err;
    } outv_t;

    logic          clk;
    logic          rst;
    logic          run;
    logic [10:0]   opcode;
    logic          zero;
    logic          mem_ack;
    logic          ir_wr, pc_wr, pc_src, reg2loc, alu_src;
    logic [1:0]    seu;
    logic [2:0]    alu_op;
    logic          mem_req, mem_wr, mem_to_reg, reg_wr;
    logic [2:0]    state;
    logic          halted;
    logic [1:0]    err;
    logic [CW-1:0] retired;

    outv_t         obs;
    logic [CW-1:0] exp_ret;
    logic [$bits(outv_t)+CW-1:0] exp_q[$];
    int            total;
    int            bad;

    multicycle_ctrl #(
        .MEM_TIMEOUT (15),
        .TO_W        (4),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .ir_wr      (ir_wr),
        .pc_wr      (pc_wr),
        .pc_src     (pc_src),
        .reg2loc    (reg2loc),
        .seu        (seu),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_to_reg (mem_to_reg),
        .reg_wr     (reg_wr),
        .state      (state),
        .halted     (halted),
        .err        (err),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb obs = {ir_wr, pc_wr, pc_src, reg2loc, seu, alu_src, alu_op,
                       mem_req, mem_wr, mem_to_reg, reg_wr, state, halted, err};

    function automatic outv_t fv(input logic [2:0] st);
        outv_t v;
        v = '0;
        v.state = st;
        return v;
    endfunction

    function automatic outv_t av(input logic [2:0] st, input logic r2l,
                                 input logic [1:0] s, input logic as,
                                 input logic [2:0] op);
        outv_t v;
        v = fv(st);
        v.reg2loc = r2l;
        v.seu     = s;
        v.alu_src = as;
        v.alu_op  = op;
        return v;
    endfunction

    function automatic outv_t fetchv();
        outv_t v;
        v = fv(3'd0);
        v.ir_wr = 1'b1;
        return v;
    endfunction

    // Queue the expectation, drive one cycle of inputs, compare at negedge.
    task automatic step(input string tag, input logic r, input logic [10:0] opc,
                        input logic z, input logic ack, input logic rs,
                        input outv_t v, input logic ret);
        logic [$bits(outv_t)+CW-1:0] exp_v;
        logic [$bits(outv_t)+CW-1:0] got_v;
        exp_q.push_back({v, exp_ret});
        if (ret) exp_ret = exp_ret + 1'b1;
        run = r; opcode = opc; zero = z; mem_ack = ack; rst = rs;
        @(negedge clk);
        exp_v = exp_q.pop_front();
        got_v = {obs, retired};
        total++;
        assert (got_v === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got_v, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic t_alu(input string tag, input logic [10:0] opc,
                         input logic as, input logic [2:0] op);
        outv_t v;
        step({tag, "_fetch"}, 1'b1, opc, 1'b0, 1'b0, 1'b0, fetchv(), 1'b0);
        step({tag, "_decode"}, 1'b1, opc, 1'b0, 1'b0, 1'b0, fv(3'd1), 1'b0);
        step({tag, "_exec"}, 1'b1, opc, 1'b0, 1'b0, 1'b0, av(3'd2, 1'b0, 2'b00, as, op), 1'b0);
        v = av(3'd4, 1'b0, 2'b00, as, op);
        v.reg_wr = 1'b1;
        v.pc_wr  = 1'b1;
        step({tag, "_wb"}, 1'b1, opc, 1'b0, 1'b0, 1'b0, v, 1'b1);
    endtask

    // Memory op with ack on MEM cycle number waitc (0-based).
    task automatic t_mem(input string tag, input logic is_st, input int waitc);
        outv_t v;
        logic [10:0] opc;
        opc = is_st ? 11'h7C0 : 11'h7C2;
        step({tag, "_fetch"}, 1'b1, opc, 1'b0, 1'b0, 1'b0, fetchv(), 1'b0);
        step({tag, "_decode"}, 1'b1, opc, 1'b0, 1'b0, 1'b0, fv(3'd1), 1'b0);
        step({tag, "_exec"}, 1'b1, opc, 1'b0, 1'b0, 1'b0, av(3'd2, is_st, 2'b01, 1'b1, 3'b010), 1'b0);
        for (int i = 0; i <= waitc; i++) begin
            v = av(3'd3, is_st, 2'b01, 1'b1, 3'b010);
            v.mem_req = 1'b1;
            v.mem_wr  = is_st;
            if (is_st && i == waitc) v.pc_wr = 1'b1;
            step({tag, "_mem"}, 1'b1, opc, 1'b0, (i == waitc), 1'b0, v, is_st && (i == waitc));
        end
        if (!is_st) begin
            v = av(3'd4, 1'b0, 2'b01, 1'b1, 3'b010);
            v.reg_wr     = 1'b1;
            v.mem_to_reg = 1'b1;
            v.pc_wr      = 1'b1;
            step({tag, "_wb"}, 1'b1, opc, 1'b0, 1'b0, 1'b0, v, 1'b1);
        end
    endtask

    task automatic t_cbz(input string tag, input logic [10:0] opc, input logic z);
        outv_t v;
        step({tag, "_fetch"}, 1'b1, opc, z, 1'b0, 1'b0, fetchv(), 1'b0);
        step({tag, "_decode"}, 1'b1, opc, z, 1'b0, 1'b0, fv(3'd1), 1'b0);
        v = av(3'd2, 1'b1, 2'b10, 1'b0, 3'b111);
        v.pc_src = z;
        v.pc_wr  = 1'b1;
        step({tag, "_exec"}, 1'b1, opc, z, 1'b0, 1'b0, v, 1'b1);
    endtask

    task automatic t_b(input string tag, input logic [10:0] opc);
        outv_t v;
        step({tag, "_fetch"}, 1'b1, opc, 1'b0, 1'b0, 1'b0, fetchv(), 1'b0);
        v = fv(3'd1);
        v.seu    = 2'b11;
        v.pc_src = 1'b1;
        v.pc_wr  = 1'b1;
        step({tag, "_decode"}, 1'b1, opc, 1'b0, 1'b0, 1'b0, v, 1'b1);
    endtask

    task automatic do_reset(input string tag, input outv_t cur);
        step(tag, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1, cur, 1'b0);
        exp_ret = '0;
    endtask

    initial begin
        outv_t v;
        total = 0; bad = 0; exp_ret = '0;
        rst = 1'b1; run = 1'b0; opcode = '0; zero = 1'b0; mem_ack = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset_state", fv(3'd0));

        for (int i = 0; i < 10; i++)
            step("idle_run0", 1'b0, 11'h458, 1'b0, 1'b0, 1'b0, fv(3'd0), 1'b0);

        t_alu("add",  11'h458, 1'b0, 3'b010);
        t_alu("sub",  11'h658, 1'b0, 3'b110);
        t_alu("and",  11'h450, 1'b0, 3'b000);
        t_alu("orr",  11'h550, 1'b0, 3'b001);
        t_alu("addi", 11'h489, 1'b1, 3'b010);
        t_alu("subi", 11'h688, 1'b1, 3'b110);
        t_mem("ldur", 1'b0, 2);
        t_mem("stur", 1'b1, 0);
        t_cbz("cbz_z1", 11'h5A0, 1'b1);
        t_cbz("cbz_z0", 11'h5A7, 1'b0);
        t_b("b_a5", 11'h0A5);
        t_b("b_bf", 11'h0BF);
        for (int i = 0; i < 6; i++) t_b("b_wrap", 11'h0A0 + 11'(i));

        // Reset during MEM, then a store acked on the final allowed cycle.
        step("rmem_fetch", 1'b1, 11'h7C2, 1'b0, 1'b0, 1'b0, fetchv(), 1'b0);
        step("rmem_decode", 1'b1, 11'h7C2, 1'b0, 1'b0, 1'b0, fv(3'd1), 1'b0);
        step("rmem_exec", 1'b1, 11'h7C2, 1'b0, 1'b0, 1'b0, av(3'd2, 1'b0, 2'b01, 1'b1, 3'b010), 1'b0);
        v = av(3'd3, 1'b0, 2'b01, 1'b1, 3'b010);
        v.mem_req = 1'b1;
        step("rmem_mem", 1'b1, 11'h7C2, 1'b0, 1'b0, 1'b0, v, 1'b0);
        step("rmem_mem", 1'b1, 11'h7C2, 1'b0, 1'b0, 1'b0, v, 1'b0);
        do_reset("rmem_rst", v);
        step("rmem_after", 1'b0, 11'h7C2, 1'b0, 1'b0, 1'b0, fv(3'd0), 1'b0);
        t_mem("st_ack_at_expiry", 1'b1, 14);

        // Illegal opcode 0x000 halts with err=01; run toggling is ignored.
        step("ill0_fetch", 1'b1, 11'h000, 1'b0, 1'b0, 1'b0, fetchv(), 1'b0);
        step("ill0_decode", 1'b1, 11'h000, 1'b0, 1'b0, 1'b0, fv(3'd1), 1'b0);
        v = fv(3'd5); v.halted = 1'b1; v.err = 2'b01;
        for (int i = 0; i < 4; i++)
            step("ill0_halt", i[0], 11'h458, 1'b0, 1'b1, 1'b0, v, 1'b0);
        do_reset("ill0_rst", v);

        // Just outside the ADDI range is illegal too.
        step("ill48a_fetch", 1'b1, 11'h48A, 1'b0, 1'b0, 1'b0, fetchv(), 1'b0);
        step("ill48a_decode", 1'b1, 11'h48A, 1'b0, 1'b0, 1'b0, fv(3'd1), 1'b0);
        v = fv(3'd5); v.halted = 1'b1; v.err = 2'b01;
        step("ill48a_halt", 1'b1, 11'h48A, 1'b0, 1'b0, 1'b0, v, 1'b0);
        do_reset("ill48a_rst", v);

        // Store with no ack: 15 MEM cycles then timeout halt.
        step("to_fetch", 1'b1, 11'h7C0, 1'b0, 1'b0, 1'b0, fetchv(), 1'b0);
        step("to_decode", 1'b1, 11'h7C0, 1'b0, 1'b0, 1'b0, fv(3'd1), 1'b0);
        step("to_exec", 1'b1, 11'h7C0, 1'b0, 1'b0, 1'b0, av(3'd2, 1'b1, 2'b01, 1'b1, 3'b010), 1'b0);
        v = av(3'd3, 1'b1, 2'b01, 1'b1, 3'b010);
        v.mem_req = 1'b1; v.mem_wr = 1'b1;
        for (int i = 0; i < 15; i++)
            step("to_mem", 1'b1, 11'h7C0, 1'b0, 1'b0, 1'b0, v, 1'b0);
        v = fv(3'd5); v.halted = 1'b1; v.err = 2'b10;
        for (int i = 0; i < 4; i++)
            step("to_halt", i[0], 11'h7C0, 1'b0, 1'b0, 1'b0, v, 1'b0);
        do_reset("to_rst", v);
        step("final_idle", 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, fv(3'd0), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
